pu_queue_scheduler: RTL and testbench
=====================================

# pu_queue_scheduler

Sequencer and arbiter for one processing unit's frontier work queue in the BFS accelerator. Round-robin arbitrates up to NUM_REQ neighbour-expansion requesters into the queue's single write port. Drains the queue head round-robin into NUM_PU per-consumer dispatch slots. Tracks a BFS level run from `start` to a quiescence-detected `level_done` pulse.

## Interface
- NODE_BITS, 32, node ID width; matches the queue.
- NUM_REQ, 4, number of push requesters (1–8).
- NUM_PU, 4, number of consumer dispatch slots (1–8).
- IDLE_CYCLES, 4, consecutive quiet cycles required before `level_done` (≥1).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  pulse; begins a level run (accepted only in IDLE).
- abort  in  1  pulse; returns to IDLE and flushes dispatch slots.
- req_valid  in  NUM_REQ  requester i has a node to push.
- req_data  in  NUM_REQ*NODE_BITS  node IDs; requester i at bits [i*NODE_BITS +: NODE_BITS].
- req_ready  out  NUM_REQ  one-hot grant; push completes when req_valid[i] & req_ready[i].
- q_wr_en  out  1  queue write strobe.
- q_wr_data  out  NODE_BITS  queue write data.
- q_full  in  1  queue full.
- q_rd_en  out  1  queue pop strobe.
- q_rd_data  in  NODE_BITS  queue head (first-word-fall-through, valid whenever !q_empty).
- q_empty  in  1  queue empty.
- pu_valid  out  NUM_PU  dispatch slot k holds a node.
- pu_data  out  NUM_PU*NODE_BITS  slot contents, slot k at [k*NODE_BITS +: NODE_BITS].
- pu_ready  in  NUM_PU  consumer k accepts slot k this cycle.
- pu_busy  in  NUM_PU  consumer k still processing a node.
- busy  out  1  state != IDLE.
- level_done  out  1  one-cycle pulse at end of level.
- pushed_count  out  32  pushes this level.
- popped_count  out  32  pops this level.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. `active` = state is RUN or DRAIN.
- IDLE: start=1 → RUN; both counters cleared to 0 on the same edge.
- RUN: quiet=1 → DRAIN, idle counter loaded with 1.
- quiet = q_empty & ~|req_valid & ~|pu_valid & ~|pu_busy.
- DRAIN: quiet=0 → RUN. Otherwise increment idle counter; at IDLE_CYCLES quiet cycles total → DONE.
- DONE: level_done=1; next cycle → IDLE.
- abort (any state): → IDLE, pu_valid cleared. abort has priority over start. start outside IDLE is ignored.
- Write arbitration is combinational, gated by active & ~q_full.
  - Grant goes to the first i with req_valid[i], searching from wr_ptr upward modulo NUM_REQ.
  - q_wr_en = |grant; q_wr_data = req_data[granted].
  - On a grant, wr_ptr ← granted+1 (mod NUM_REQ) and pushed_count increments.
- Dispatch is gated by active & ~q_empty.
  - Target slot = first k with pu_valid[k]=0, searching from rd_ptr upward modulo NUM_PU.
  - A slot being accepted in the current cycle is NOT considered free.
  - On a dispatch: q_rd_en=1 (combinational), pu_data[k] ← q_rd_data, pu_valid[k] ← 1, rd_ptr ← k+1, popped_count increments.
- A slot clears when pu_valid[k] & pu_ready[k]. pu_data is held stable while pu_valid is high.
- At most one push and one pop per cycle. Both in the same cycle are permitted.
- Counters are 32-bit and wrap modulo 2^32.

## Timing
- Reset values: req_ready=0, q_wr_en=0, q_rd_en=0, pu_valid=0, pu_data=0, busy=0, level_done=0, counters=0, wr_ptr=rd_ptr=0, state IDLE.
- Push path is zero latency: req_valid → req_ready/q_wr_en in the same cycle, no registered stage. q_full is sampled combinationally, so no push is ever issued while q_full=1.
- Pop latency: q_rd_en in cycle N → pu_valid[k]=1 in cycle N+1.
- A push in cycle N is not visible for pop before N+1, because q_empty comes from the queue's registered pointers.
- level_done asserts no earlier than IDLE_CYCLES+1 cycles after the last non-quiet cycle.
- Slot throughput: a consumer with pu_ready tied high gets one node every 2 cycles (accept, then re-dispatch).
- Reset mid-operation forces every output to its reset value immediately (asynchronous). The queue resets independently.

## Test plan
- Fairness: start; req_valid=4'b1111 held, q_full=0 → grants 0,1,2,3,0 on consecutive cycles; pushed_count=5 after 5 cycles.
- Backpressure: q_full=1 with req_valid=4'b0101 → req_ready=0 and q_wr_en=0. Drop q_full → grant 0, then 2.
- Dispatch: queue holds 10,11,12; NUM_PU=4, pu_ready=0 → slots 0,1,2 load 10,11,12 on cycles N+1..N+3. q_rd_en deasserts once q_empty=1; popped_count=3.
- Slot reuse: all slots full, queue non-empty → q_rd_en=0. Pulse pu_ready[2] → slot 2 reloads in the following cycle.
- Level end: IDLE_CYCLES=4; all inputs go quiet at cycle T → level_done=1 at T+4 only, then busy=0. A req_valid blip at T+2 restarts the count.
- Abort/reset: abort while pu_valid=4'b1011 → pu_valid=0 and busy=0 next cycle. Assert rst_n=0 mid-run → all outputs zero immediately.

Source files
------------

// File: rtl/pu_queue_scheduler_if.sv
// rtl/pu_queue_scheduler_if.sv - requester, queue-port and dispatch-slot signals of pu_queue_scheduler
interface pu_queue_scheduler_if #(
  parameter int NODE_BITS = 32,
  parameter int NUM_REQ   = 4,
  parameter int NUM_PU    = 4
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*NODE_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         q_wr_en;
  logic [NODE_BITS-1:0]         q_wr_data;
  logic                         q_full;
  logic                         q_rd_en;
  logic [NODE_BITS-1:0]         q_rd_data;
  logic                         q_empty;
  logic [NUM_PU-1:0]            pu_valid;
  logic [NUM_PU*NODE_BITS-1:0]  pu_data;
  logic [NUM_PU-1:0]            pu_ready;
  logic [NUM_PU-1:0]            pu_busy;

  modport master (
    input  req_valid, req_data, q_full, q_rd_data, q_empty, pu_ready, pu_busy,
    output req_ready, q_wr_en, q_wr_data, q_rd_en, pu_valid, pu_data
  );

  modport slave (
    output req_valid, req_data, q_full, q_rd_data, q_empty, pu_ready, pu_busy,
    input  req_ready, q_wr_en, q_wr_data, q_rd_en, pu_valid, pu_data
  );
endinterface

// File: rtl/pu_queue_scheduler.sv
// rtl/pu_queue_scheduler.sv - round-robin push arbiter, round-robin slot dispatcher and BFS level sequencer
module pu_queue_scheduler #(
  parameter int NODE_BITS   = 32,
  parameter int NUM_REQ     = 4,
  parameter int NUM_PU      = 4,
  parameter int IDLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  pu_queue_scheduler_if.master  bus,
  output logic                  busy_o,
  output logic                  level_done_o,
  output logic [31:0]           pushed_count_o,
  output logic [31:0]           popped_count_o
);
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                      state_q, state_d;
  logic [RW-1:0]               wr_ptr_q, wr_ptr_d, gnt_idx, cand_r;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d, slot_idx, cand_p;
  logic [NUM_REQ-1:0]          grant;
  logic [NUM_PU-1:0]           pu_valid_q, pu_valid_d;
  logic [NUM_PU*NODE_BITS-1:0] pu_data_q, pu_data_d;
  logic [31:0]                 pushed_q, pushed_d, popped_q, popped_d, idle_q, idle_d;
  logic                        active, quiet, push, pop, clear_cnt;

  function automatic int wrap(input int s, input int n);
    return (s >= n) ? s - n : s;
  endfunction

  assign active = (state_q == RUN) || (state_q == DRAIN);
  assign quiet  = bus.q_empty & ~|bus.req_valid & ~|pu_valid_q & ~|bus.pu_busy;

  // First requesting port at or after wr_ptr wins; no push ever while the queue is full.
  always_comb begin
    push    = 1'b0;
    gnt_idx = '0;
    cand_r  = '0;
    grant   = '0;
    if (active && !bus.q_full) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        cand_r = RW'(wrap(int'(wr_ptr_q) + j, NUM_REQ));
        if (!push && bus.req_valid[cand_r]) begin
          push    = 1'b1;
          gnt_idx = cand_r;
        end
      end
    end
    if (push) grant[gnt_idx] = 1'b1;
    wr_ptr_d = push ? RW'(wrap(int'(gnt_idx) + 1, NUM_REQ)) : wr_ptr_q;
  end

  // A slot being accepted this cycle still counts as occupied, so refill lands one cycle later.
  always_comb begin
    pop      = 1'b0;
    slot_idx = '0;
    cand_p   = '0;
    if (active && !bus.q_empty) begin
      for (int k = 0; k < NUM_PU; k++) begin
        cand_p = PW'(wrap(int'(rd_ptr_q) + k, NUM_PU));
        if (!pop && !pu_valid_q[cand_p]) begin
          pop      = 1'b1;
          slot_idx = cand_p;
        end
      end
    end
    rd_ptr_d   = pop ? PW'(wrap(int'(slot_idx) + 1, NUM_PU)) : rd_ptr_q;
    pu_valid_d = pu_valid_q & ~bus.pu_ready;
    pu_data_d  = pu_data_q;
    if (pop) begin
      pu_valid_d[slot_idx] = 1'b1;
      pu_data_d[int'(slot_idx)*NODE_BITS +: NODE_BITS] = bus.q_rd_data;
    end
    if (abort_i) pu_valid_d = '0;
  end

  always_comb begin
    state_d   = state_q;
    idle_d    = idle_q;
    clear_cnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = RUN;
          clear_cnt = 1'b1;
        end
      end
      RUN: begin
        if (quiet) begin
          state_d = DRAIN;
          idle_d  = 32'd1;
        end
      end
      DRAIN: begin
        if (!quiet) state_d = RUN;
        else if (idle_q + 32'd1 >= 32'(IDLE_CYCLES)) state_d = DONE;
        else idle_d = idle_q + 32'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d   = IDLE;
      clear_cnt = 1'b0;
    end
    pushed_d = clear_cnt ? 32'd0 : pushed_q + {31'd0, push};
    popped_d = clear_cnt ? 32'd0 : popped_q + {31'd0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pu_valid_q <= '0;
      pu_data_q  <= '0;
      pushed_q   <= '0;
      popped_q   <= '0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pu_valid_q <= pu_valid_d;
      pu_data_q  <= pu_data_d;
      pushed_q   <= pushed_d;
      popped_q   <= popped_d;
      idle_q     <= idle_d;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.q_wr_en    = push;
  assign bus.q_wr_data  = bus.req_data[int'(gnt_idx)*NODE_BITS +: NODE_BITS];
  assign bus.q_rd_en    = pop;
  assign bus.pu_valid   = pu_valid_q;
  assign bus.pu_data    = pu_data_q;
  assign busy_o         = (state_q != IDLE);
  assign level_done_o   = (state_q == DONE);
  assign pushed_count_o = pushed_q;
  assign popped_count_o = popped_q;
endmodule

// File: tb/tb_pu_queue_scheduler.sv
// tb/tb_pu_queue_scheduler.sv - directed bench with a FIFO environment and a level-run reference model
module tb_pu_queue_scheduler;
  localparam int NB = 32, NR = 4, NP = 4, IC = 4, DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, abort = 1'b0, force_full = 1'b0;
  logic        busy, level_done;
  logic [31:0] pushed, popped;
  int          n_pass = 0, n_total = 0;

  logic [NB-1:0] fifo[$];

  // Reference: mode 0 idle, 1 level running, 2 done pulse; quiet_run counts consecutive quiet running cycles.
  int          m_mode, m_wr_ptr, m_rd_ptr, m_quiet;
  logic [NP-1:0] m_sv;
  logic [NB-1:0] m_sd[NP];
  logic [31:0] m_push, m_pop;

  logic [3:0]  fair_exp[5] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1};

  pu_queue_scheduler_if #(.NODE_BITS(NB), .NUM_REQ(NR), .NUM_PU(NP)) bus ();

  pu_queue_scheduler #(.NODE_BITS(NB), .NUM_REQ(NR), .NUM_PU(NP), .IDLE_CYCLES(IC)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .bus(bus),
    .busy_o(busy), .level_done_o(level_done),
    .pushed_count_o(pushed), .popped_count_o(popped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_wr_ptr = 0; m_rd_ptr = 0; m_quiet = 0;
    m_sv = '0; m_push = 0; m_pop = 0;
    for (int k = 0; k < NP; k++) m_sd[k] = '0;
  endtask

  task automatic refresh_q();
    bus.q_empty   = (fifo.size() == 0);
    bus.q_rd_data = (fifo.size() > 0) ? fifo[0] : '0;
    bus.q_full    = force_full || (fifo.size() >= DEPTH);
  endtask

  task automatic model_cycle();
    int g, s, idx;
    logic [NR-1:0] e_ready;
    bit quiet;
    if (!rst_n) model_reset();
    g = -1;
    s = -1;
    if (m_mode == 1 && !bus.q_full)
      for (int j = 0; j < NR; j++) begin
        idx = (m_wr_ptr + j) % NR;
        if (g < 0 && bus.req_valid[idx]) g = idx;
      end
    if (m_mode == 1 && !bus.q_empty)
      for (int k = 0; k < NP; k++) begin
        idx = (m_rd_ptr + k) % NP;
        if (s < 0 && !m_sv[idx]) s = idx;
      end
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;
    chk("m_req_ready", 32'(bus.req_ready), 32'(e_ready));
    chk("m_q_wr_en", 32'(bus.q_wr_en), 32'(g >= 0));
    if (g >= 0) chk("m_q_wr_data", bus.q_wr_data, bus.req_data[g*NB +: NB]);
    chk("m_q_rd_en", 32'(bus.q_rd_en), 32'(s >= 0));
    chk("m_pu_valid", 32'(bus.pu_valid), 32'(m_sv));
    for (int k = 0; k < NP; k++)
      if (m_sv[k]) chk("m_pu_data", bus.pu_data[k*NB +: NB], m_sd[k]);
    chk("m_busy", 32'(busy), 32'(m_mode != 0));
    chk("m_level_done", 32'(level_done), 32'(m_mode == 2));
    chk("m_pushed", pushed, m_push);
    chk("m_popped", popped, m_pop);
    if (!rst_n) return;
    quiet = bus.q_empty && (bus.req_valid == 0) && (m_sv == 0) && (bus.pu_busy == 0);
    for (int k = 0; k < NP; k++) if (bus.pu_ready[k]) m_sv[k] = 1'b0;
    if (s >= 0) begin
      m_sv[s] = 1'b1; m_sd[s] = bus.q_rd_data; m_rd_ptr = (s + 1) % NP; m_pop++;
    end
    if (g >= 0) begin
      m_wr_ptr = (g + 1) % NR; m_push++;
    end
    if (abort) begin
      m_mode = 0; m_sv = '0;
    end else if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_push = 0; m_pop = 0; m_quiet = 0; end
    end else if (m_mode == 1) begin
      if (quiet) begin
        m_quiet++;
        if (m_quiet >= ((IC < 2) ? 2 : IC)) m_mode = 2;
      end else m_quiet = 0;
    end else m_mode = 0;
  endtask

  // Compare against the model, then clock once and let the FIFO environment react to the strobes.
  task automatic step();
    logic we, re;
    logic [NB-1:0] wd;
    model_cycle();
    we = bus.q_wr_en; re = bus.q_rd_en; wd = bus.q_wr_data;
    @(posedge clk);
    #1;
    if (!rst_n) fifo.delete();
    else begin
      if (re && fifo.size() > 0) void'(fifo.pop_front());
      if (we) fifo.push_back(wd);
    end
    refresh_q();
  endtask

  task automatic do_reset();
    bus.req_valid = '0; bus.pu_ready = '0; bus.pu_busy = '0;
    start = 0; abort = 0; force_full = 0;
    rst_n = 0;
    #1;
    step(); step();
    rst_n = 1;
    #2;
  endtask

  initial begin
    bus.req_valid = '0; bus.pu_ready = '0; bus.pu_busy = '0;
    for (int i = 0; i < NR; i++) bus.req_data[i*NB +: NB] = 100 + i;
    refresh_q();
    model_reset();
    #1 rst_n = 0;
    #1;
    step(); step();
    rst_n = 1;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_level_done", 32'(level_done), 0);
    chk("rst_pushed", pushed, 0);
    chk("rst_pu_valid", 32'(bus.pu_valid), 0);
    chk("rst_pu_data0", bus.pu_data[31:0], 0);

    // Fairness: all four requesting, queue never full.
    start = 1; #2; step(); start = 0; bus.req_valid = '1; #2;
    for (int n = 0; n < 5; n++) begin
      chk("fair_grant", 32'(bus.req_ready), 32'(fair_exp[n]));
      step(); #2;
    end
    chk("fair_pushed", pushed, 5);
    bus.req_valid = '0;

    // Backpressure then release.
    do_reset();
    start = 1; #2; step(); start = 0;
    force_full = 1; refresh_q(); bus.req_valid = 4'b0101; #2;
    chk("bp_ready", 32'(bus.req_ready), 0);
    chk("bp_wr_en", 32'(bus.q_wr_en), 0);
    step(); force_full = 0; refresh_q(); #2;
    chk("bp_grant0", 32'(bus.req_ready), 1);
    chk("bp_data0", bus.q_wr_data, 100);
    step(); #2;
    chk("bp_grant2", 32'(bus.req_ready), 4);
    chk("bp_data2", bus.q_wr_data, 102);
    step(); bus.req_valid = '0; #2;

    // Dispatch of 10,11,12 into empty slots with consumers stalled.
    do_reset();
    fifo.push_back(10); fifo.push_back(11); fifo.push_back(12); refresh_q();
    start = 1; #2; step(); start = 0; #2;
    chk("disp_rd_en", 32'(bus.q_rd_en), 1);
    step(); #2;
    chk("disp_valid1", 32'(bus.pu_valid), 4'b0001);
    chk("disp_data0", bus.pu_data[0*NB +: NB], 10);
    step(); #2;
    chk("disp_valid2", 32'(bus.pu_valid), 4'b0011);
    chk("disp_data1", bus.pu_data[1*NB +: NB], 11);
    step(); #2;
    chk("disp_valid3", 32'(bus.pu_valid), 4'b0111);
    chk("disp_data2", bus.pu_data[2*NB +: NB], 12);
    chk("disp_rd_idle", 32'(bus.q_rd_en), 0);
    chk("disp_popped", popped, 3);

    // Slot reuse: fill slot 3, then free slot 2 and watch it refill.
    fifo.push_back(20); fifo.push_back(21); refresh_q(); #2;
    chk("reuse_rd_en", 32'(bus.q_rd_en), 1);
    step(); #2;
    chk("reuse_full", 32'(bus.pu_valid), 4'b1111);
    chk("reuse_stall", 32'(bus.q_rd_en), 0);
    bus.pu_ready = 4'b0100; #2;
    chk("reuse_accept_busy", 32'(bus.q_rd_en), 0);
    step(); bus.pu_ready = '0; #2;
    chk("reuse_freed", 32'(bus.pu_valid), 4'b1011);
    chk("reuse_rd_en2", 32'(bus.q_rd_en), 1);
    step(); #2;
    chk("reuse_refill", 32'(bus.pu_valid), 4'b1111);
    chk("reuse_data2", bus.pu_data[2*NB +: NB], 21);

    // Abort with three slots occupied.
    bus.pu_ready = 4'b0100; #2; step(); bus.pu_ready = '0; #2;
    chk("abort_pre", 32'(bus.pu_valid), 4'b1011);
    abort = 1; #2; step(); abort = 0; #2;
    chk("abort_valid", 32'(bus.pu_valid), 0);
    chk("abort_busy", 32'(busy), 0);

    // Level end: one node flows through, then quiet from cycle T.
    do_reset();
    bus.pu_ready = '1;
    start = 1; #2; step(); start = 0; bus.req_valid = 4'b0001; #2;
    step(); bus.req_valid = '0; #2;
    step(); #2;
    step(); #2;
    chk("lvl_T", 32'(level_done), 0);
    for (int n = 1; n < 4; n++) begin
      step(); #2;
      chk("lvl_early", 32'(level_done), 0);
    end
    step(); #2;
    chk("lvl_T4", 32'(level_done), 1);
    step(); #2;
    chk("lvl_idle", 32'(busy), 0);

    // Level end with a requester blip at T+2 (queue held full so nothing is pushed).
    force_full = 1; refresh_q();
    start = 1; #2; step(); start = 0; #2;
    step(); #2;
    step(); bus.req_valid = 4'b0001; #2;
    step(); bus.req_valid = '0; #2;
    step(); #2;
    chk("blip_T4", 32'(level_done), 0);
    step(); #2;
    step(); #2;
    chk("blip_T6", 32'(level_done), 0);
    step(); #2;
    chk("blip_T7", 32'(level_done), 1);
    step(); #2;

    // Asynchronous reset in the middle of a run.
    force_full = 0; refresh_q(); bus.pu_ready = '0;
    start = 1; #2; step(); start = 0; bus.req_valid = '1; #2;
    step(); #2;
    step(); #2;
    chk("mid_pushed", pushed, 2);
    rst_n = 0; #1;
    chk("mid_rst_ready", 32'(bus.req_ready), 0);
    chk("mid_rst_wr_en", 32'(bus.q_wr_en), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_pushed", pushed, 0);
    chk("mid_rst_valid", 32'(bus.pu_valid), 0);
    chk("mid_rst_data0", bus.pu_data[31:0], 0);
    bus.req_valid = '0;
    step(); step();
    rst_n = 1; #2;
    step(); #2;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
